cdc_tx_queue: RTL and testbench
===============================

Name: cdc_tx_queue

Overview:
- Source-domain (clk_a) queue feeding the toggle-handshake CDC synchronizer.
- Accepts a valid/ready write stream and buffers words in a small synchronous FIFO.
- Launches one word at a time into the synchronizer as a single-cycle valid pulse, and only while the synchronizer reports not-busy.
- Decouples bursty producers from the multi-cycle round-trip latency of the handshake.

Parameters:
- DATA_WIDTH, 8, width of each data word; must match the downstream synchronizer.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- Derived localparam CNT_W = $clog2(DEPTH)+1.

Ports:
- i_clk_a  in  1  source-domain clock
- i_rst_n_a  in  1  asynchronous active-low reset
- i_wr_valid  in  1  producer has a word
- i_wr_data  in  DATA_WIDTH  producer word
- o_wr_ready  out  1  queue can accept a word (= !full)
- i_tx_busy  in  1  busy from the synchronizer (high while a transfer is outstanding)
- o_tx_valid  out  1  single-cycle launch pulse to the synchronizer
- o_tx_data  out  DATA_WIDTH  word presented with o_tx_valid
- o_level  out  CNT_W  current FIFO occupancy, 0..DEPTH
- o_empty  out  1  occupancy == 0

Behaviour:
- Clocking and reset:
  - Clock is i_clk_a. Reset is i_rst_n_a, asynchronous, active-low. All state is in the clk_a domain.
  - Reset values: o_tx_valid=0, o_tx_data=0, o_level=0, o_empty=1, o_wr_ready=1, FSM=IDLE, read and write pointers = 0.
- Write side:
  - A push occurs on a clock edge where i_wr_valid && o_wr_ready. The word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
  - o_wr_ready is combinational from the registered count (!full). It does not depend on i_wr_valid.
- FSM states:
  - IDLE: if count>0 and i_tx_busy==0, then pop the head word into the o_tx_data register, set o_tx_valid=1, and go to SEND. Otherwise stay in IDLE with o_tx_valid=0.
  - SEND: o_tx_valid is high for exactly this one cycle. Next edge: o_tx_valid=0, go to GUARD.
  - GUARD: one dead cycle that lets the synchronizer's busy rise. Next edge: go to IDLE. i_tx_busy is ignored in SEND and GUARD.
- Latency and throughput:
  - A word written into an empty queue with busy low appears on o_tx_valid 2 cycles after the write edge (push edge, then launch-decision edge).
  - Minimum spacing between launches is 3 cycles. Actual spacing is bounded by the deassertion of i_tx_busy.
- o_tx_data holds the last launched word until the next launch. It is never X after reset.
- Count and pointers:
  - Count updates +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - A push and a pop in the same cycle are legal at any occupancy below DEPTH.
  - When full, no push is accepted; a pop that cycle frees the slot for the next cycle only.
  - Pointers wrap modulo DEPTH. FIFO order is strict.
- Pop when empty never occurs, because IDLE requires count>0.
- Reset mid-operation (including in SEND with o_tx_valid high): all outputs return to their reset values immediately. Buffered words are discarded.

Optional Feature:
- Macro CDC_TX_QUEUE_FLUSH_EN.
- When defined:
  - Adds input i_flush (1 bit, clk_a).
  - On an edge with i_flush=1, pointers and count clear to 0 and any concurrent push is dropped.
  - An in-progress SEND/GUARD sequence completes normally; the already-launched word is unaffected.
  - o_wr_ready is forced low during the flush cycle.
- When undefined: no i_flush port; the queue clears only on reset.

Test Plan:
- Reset check: with i_rst_n_a=0, confirm o_tx_valid=0, o_tx_data=0, o_level=0, o_empty=1, o_wr_ready=1.
- Single word, busy=0: write 0xA5 → o_tx_valid high for exactly 1 cycle, 2 cycles after the write edge, with o_tx_data=0xA5; o_level returns to 0.
- Burst of 4 words 0x01..0x04 with DEPTH=4:
  - i_tx_busy is modelled high for 6 cycles after each launch.
  - Required: o_level peaks at 3 (one word popped immediately), o_wr_ready stays high, and launches appear in order 0x01..0x04.
  - Launch spacing is never below 3 cycles, and no launch occurs while busy=1 in IDLE.
- Full condition: hold i_tx_busy=1 and write 5 words 0x10..0x14 → after the initial launch of 0x10, o_level=4 and o_wr_ready=0; 0x15 is refused. Release busy → remaining words drain in order and o_wr_ready reasserts after the first pop.
- Simultaneous push/pop at level 2 during an IDLE launch → o_level stays 2, and the data order is preserved across pointer wrap (run 3×DEPTH words).
- Reset asserted during SEND → o_tx_valid drops asynchronously and queue contents are lost. With CDC_TX_QUEUE_FLUSH_EN: i_flush at level 3 → o_level=0 and o_empty=1 next cycle, with no further launches.

Source files
------------

// File: rtl/cdc_tx_queue_if.sv
// rtl/cdc_tx_queue_if.sv - producer/launch port bundle for cdc_tx_queue; CDC_TX_QUEUE_FLUSH_EN adds i_flush
interface cdc_tx_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  i_wr_valid;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  o_wr_ready;
    logic                  i_tx_busy;
    logic                  o_tx_valid;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic [CNT_W-1:0]      o_level;
    logic                  o_empty;
`ifdef CDC_TX_QUEUE_FLUSH_EN
    logic                  i_flush;

    modport master (
        output i_wr_valid, i_wr_data, i_tx_busy, i_flush,
        input  o_wr_ready, o_tx_valid, o_tx_data, o_level, o_empty
    );
    modport slave (
        input  i_wr_valid, i_wr_data, i_tx_busy, i_flush,
        output o_wr_ready, o_tx_valid, o_tx_data, o_level, o_empty
    );
`else
    modport master (
        output i_wr_valid, i_wr_data, i_tx_busy,
        input  o_wr_ready, o_tx_valid, o_tx_data, o_level, o_empty
    );
    modport slave (
        input  i_wr_valid, i_wr_data, i_tx_busy,
        output o_wr_ready, o_tx_valid, o_tx_data, o_level, o_empty
    );
`endif
endinterface

// File: rtl/cdc_tx_queue.sv
// rtl/cdc_tx_queue.sv - clk_a FIFO that launches one word per handshake into the toggle CDC synchronizer
// Optional flush input enabled by CDC_TX_QUEUE_FLUSH_EN.
module cdc_tx_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic          i_clk_a,
    input  logic          i_rst_n_a,
    cdc_tx_queue_if.slave q
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  full;
    logic                  flush;
    logic                  push;
    logic                  pop;

`ifdef CDC_TX_QUEUE_FLUSH_EN
    assign flush = q.i_flush;
`else
    assign flush = 1'b0;
`endif

    assign full         = (count == CNT_W'(DEPTH));
    assign q.o_wr_ready = !full && !flush;
    assign push         = q.i_wr_valid && q.o_wr_ready;
    // Launch only from IDLE, so busy is re-examined after every SEND/GUARD pair.
    assign pop          = (state == IDLE) && (count != '0) && !q.i_tx_busy && !flush;

    always_ff @(posedge i_clk_a or negedge i_rst_n_a) begin
        if (!i_rst_n_a) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = SEND;
            SEND:    state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q.o_tx_valid = 1'b0;
        if (state == SEND) begin
            q.o_tx_valid = 1'b1;
        end
    end

    always_ff @(posedge i_clk_a) begin
        if (push) begin
            mem[wr_ptr] <= q.i_wr_data;
        end
    end

    always_ff @(posedge i_clk_a or negedge i_rst_n_a) begin
        if (!i_rst_n_a) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign q.o_tx_data = tx_data;
    assign q.o_level   = count;
    assign q.o_empty   = (count == '0);
endmodule

// File: tb/tb_cdc_tx_queue.sv
// tb/tb_cdc_tx_queue.sv - scoreboard bench for cdc_tx_queue
module tb_cdc_tx_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    cdc_tx_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) qif ();

    cdc_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk_a   (clk),
        .i_rst_n_a (rst_n),
        .q         (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] sb[$];
    int  cyc = 0;
    logic edge_busy = 1'b0;
    int  last_launch = -100;
    int  n_launch = 0;
    int  max_level = 0;
    bit  saw_not_ready = 1'b0;

    bit  busy_mode = 1'b0;
    int  busy_len = 6;
    int  busy_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            edge_busy = qif.i_tx_busy;
        end
    end

    // Synchronizer stand-in: busy rises with the launch pulse and holds busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_mode) begin
                if (qif.o_tx_valid) begin
                    qif.i_tx_busy = 1'b1;
                    busy_cnt = busy_len;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) qif.i_tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (int'(qif.o_level) > max_level) max_level = int'(qif.o_level);
            if (!qif.o_wr_ready) saw_not_ready = 1'b1;
            if (qif.o_tx_valid === 1'b1) begin
                n_launch++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL launch_unexpected: got data %h, expected no launch", qif.o_tx_data);
                end else begin
                    logic [DW-1:0] exp_d;
                    exp_d = sb.pop_front();
                    if (qif.o_tx_data !== exp_d) begin
                        n_err++;
                        $display("FAIL launch_data: got %h, expected %h", qif.o_tx_data, exp_d);
                    end
                end
                n_cmp++;
                if (cyc - last_launch < 3) begin
                    n_err++;
                    $display("FAIL launch_spacing: got %0d cycles, expected >= 3", cyc - last_launch);
                end
                n_cmp++;
                if (edge_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL launch_while_busy: busy was %b at launch edge, expected 0", edge_busy);
                end
                last_launch = cyc;
            end
        end
    end

    task automatic write_word(input logic [DW-1:0] d);
        @(negedge clk);
        qif.i_wr_valid = 1'b1;
        qif.i_wr_data  = d;
        if (qif.o_wr_ready) sb.push_back(d);
    endtask

    task automatic end_write();
        @(negedge clk);
        qif.i_wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || qif.o_level != '0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (sb.size() != 0 || qif.o_level != '0) begin
            n_err++;
            $display("FAIL drain_timeout: level %0d pending %0d, expected 0 and 0", qif.o_level, sb.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (qif.o_tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b expected 0", qif.o_tx_valid); end
        n_cmp++; if (qif.o_tx_data !== '0) begin n_err++; $display("FAIL rst_tx_data: got %h expected 00", qif.o_tx_data); end
        n_cmp++; if (qif.o_level !== '0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", qif.o_level); end
        n_cmp++; if (qif.o_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b expected 1", qif.o_empty); end
        n_cmp++; if (qif.o_wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b expected 1", qif.o_wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        busy_mode = 1'b0;
        qif.i_tx_busy = 1'b0;
        write_word(8'hA5);
        end_write();
        n_cmp++; if (qif.o_tx_valid !== 1'b0) begin n_err++; $display("FAIL single_early: tx_valid %b expected 0", qif.o_tx_valid); end
        n_cmp++; if (qif.o_level !== CNT_W'(1)) begin n_err++; $display("FAIL single_level1: got %0d expected 1", qif.o_level); end
        @(negedge clk);
        n_cmp++; if (qif.o_tx_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: tx_valid %b expected 1", qif.o_tx_valid); end
        @(negedge clk);
        n_cmp++; if (qif.o_tx_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: tx_valid %b expected 0", qif.o_tx_valid); end
        n_cmp++; if (qif.o_level !== '0) begin n_err++; $display("FAIL single_level0: got %0d expected 0", qif.o_level); end
        n_cmp++; if (qif.o_tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold: got %h expected a5", qif.o_tx_data); end
        wait_drain(20);
    endtask

    task automatic test_burst();
        busy_len = 6;
        busy_cnt = 0;
        qif.i_tx_busy = 1'b0;
        busy_mode = 1'b1;
        max_level = 0;
        saw_not_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) write_word(DW'(i));
        end_write();
        wait_drain(200);
        n_cmp++; if (max_level != 3) begin n_err++; $display("FAIL burst_peak_level: got %0d expected 3", max_level); end
        n_cmp++; if (saw_not_ready) begin n_err++; $display("FAIL burst_wr_ready: got ready low, expected always high"); end
    endtask

    task automatic test_full();
        int n;
        busy_len = 1000;
        busy_cnt = 0;
        qif.i_tx_busy = 1'b0;
        busy_mode = 1'b1;
        for (int i = 0; i < 5; i++) write_word(8'h10 + DW'(i));
        @(negedge clk);
        qif.i_wr_data = 8'h15;
        n_cmp++; if (qif.o_level !== CNT_W'(4)) begin n_err++; $display("FAIL full_level: got %0d expected 4", qif.o_level); end
        n_cmp++; if (qif.o_wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready: got %b expected 0", qif.o_wr_ready); end
        end_write();
        n_cmp++; if (qif.o_level !== CNT_W'(4)) begin n_err++; $display("FAIL full_refuse: got level %0d expected 4", qif.o_level); end
        busy_mode = 1'b0;
        qif.i_tx_busy = 1'b0;
        n = 0;
        while (qif.o_level == CNT_W'(4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (qif.o_level !== CNT_W'(3)) begin n_err++; $display("FAIL full_first_pop: level %0d expected 3", qif.o_level); end
        n_cmp++; if (qif.o_wr_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %b expected 1", qif.o_wr_ready); end
        wait_drain(100);
    endtask

    task automatic test_simul();
        busy_mode = 1'b0;
        qif.i_tx_busy = 1'b1;
        write_word(8'h30);
        write_word(8'h31);
        end_write();
        n_cmp++; if (qif.o_level !== CNT_W'(2)) begin n_err++; $display("FAIL simul_preload: level %0d expected 2", qif.o_level); end
        for (int i = 2; i < 3 * DEPTH; i++) begin
            @(negedge clk);
            qif.i_tx_busy  = 1'b0;
            qif.i_wr_valid = 1'b1;
            qif.i_wr_data  = 8'h30 + DW'(i);
            if (qif.o_wr_ready) sb.push_back(8'h30 + DW'(i));
            @(negedge clk);
            qif.i_wr_valid = 1'b0;
            n_cmp++; if (qif.o_level !== CNT_W'(2)) begin n_err++; $display("FAIL simul_level: word %0d level %0d expected 2", i, qif.o_level); end
            @(negedge clk);
        end
        wait_drain(100);
    endtask

    task automatic test_reset_mid();
        int launches;
        busy_mode = 1'b0;
        qif.i_tx_busy = 1'b0;
        write_word(8'h5A);
        write_word(8'h5B);
        end_write();
        n_cmp++; if (qif.o_tx_valid !== 1'b1) begin n_err++; $display("FAIL rmid_in_send: tx_valid %b expected 1", qif.o_tx_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (qif.o_tx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_tx_valid: got %b expected 0", qif.o_tx_valid); end
        n_cmp++; if (qif.o_level !== '0) begin n_err++; $display("FAIL rmid_level: got %0d expected 0", qif.o_level); end
        n_cmp++; if (qif.o_empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b expected 1", qif.o_empty); end
        n_cmp++; if (qif.o_tx_data !== '0) begin n_err++; $display("FAIL rmid_tx_data: got %h expected 00", qif.o_tx_data); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        launches = n_launch;
        repeat (8) @(negedge clk);
        n_cmp++; if (n_launch != launches) begin n_err++; $display("FAIL rmid_no_launch: got %0d launches expected 0", n_launch - launches); end
    endtask

`ifdef CDC_TX_QUEUE_FLUSH_EN
    task automatic test_flush();
        int launches;
        busy_mode = 1'b0;
        qif.i_tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) write_word(8'h40 + DW'(i));
        end_write();
        n_cmp++; if (qif.o_level !== CNT_W'(3)) begin n_err++; $display("FAIL flush_pre_level: got %0d expected 3", qif.o_level); end
        @(negedge clk);
        qif.i_flush    = 1'b1;
        qif.i_wr_valid = 1'b1;
        qif.i_wr_data  = 8'h77;
        #1;
        n_cmp++; if (qif.o_wr_ready !== 1'b0) begin n_err++; $display("FAIL flush_wr_ready: got %b expected 0", qif.o_wr_ready); end
        @(negedge clk);
        qif.i_flush    = 1'b0;
        qif.i_wr_valid = 1'b0;
        n_cmp++; if (qif.o_level !== '0) begin n_err++; $display("FAIL flush_level: got %0d expected 0", qif.o_level); end
        n_cmp++; if (qif.o_empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b expected 1", qif.o_empty); end
        sb.delete();
        qif.i_tx_busy = 1'b0;
        launches = n_launch;
        repeat (10) @(negedge clk);
        n_cmp++; if (n_launch != launches) begin n_err++; $display("FAIL flush_no_launch: got %0d launches expected 0", n_launch - launches); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        qif.i_wr_valid = 1'b0;
        qif.i_wr_data  = '0;
        qif.i_tx_busy  = 1'b0;
`ifdef CDC_TX_QUEUE_FLUSH_EN
        qif.i_flush    = 1'b0;
`endif
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_simul();
        test_reset_mid();
`ifdef CDC_TX_QUEUE_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
